// File: rtl/dvp_capture.sv
// DVP camera capture: sync detection, byte-to-pixel packing and a FWFT pixel FIFO.
// Define DVP_CAPTURE_CROP_EN to add the CROP_* window ports and in-window filtering.
module dvp_capture #(
    parameter int DATA_W     = 8,
    parameter int BPP        = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 11,
    parameter bit VSYNC_POL  = 1'b1
) (
    input  logic                  PCLK,
    input  logic                  RESET_N,
    input  logic [DATA_W-1:0]     DATA_IN,
    input  logic                  HREF,
    input  logic                  VSYNC,
    input  logic                  ENABLE,
    output logic [BPP*DATA_W-1:0] PIX_DATA,
    output logic                  PIX_SOF,
    output logic                  PIX_EOL,
    output logic                  PIX_VALID,
    input  logic                  PIX_READY,
    output logic                  OVERFLOW,
    input  logic                  OVF_CLR,
    output logic [15:0]           FRAME_CNT,
    output logic [CNT_W-1:0]      LINE_CNT
`ifdef DVP_CAPTURE_CROP_EN
    ,
    input  logic [CNT_W-1:0]      CROP_X0,
    input  logic [CNT_W-1:0]      CROP_Y0,
    input  logic [CNT_W-1:0]      CROP_W,
    input  logic [CNT_W-1:0]      CROP_H
`endif
);

    localparam int PIX_W = BPP * DATA_W;
    localparam int PH_W  = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACTIVE} state_t;

    typedef struct packed {
        logic             sof;
        logic             eol;
        logic [PIX_W-1:0] data;
    } pix_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic [DATA_W-1:0] data_q;
    logic              href_q, href_d, vsync_q, vsync_d;
    logic              href_rise, href_fall, fs, frame_start;
    state_t            state;
    logic [PH_W-1:0]   phase, phase_cur;
    logic [CNT_W-1:0]  x_cnt, x_cur, y_cnt, line_acc;
    logic              line_ok, capturing, pix_done, in_win;
    logic [PIX_W-1:0]  pix_next;
    pix_t              stage, push, head;
    logic              stage_valid, sof_pending, push_valid;

    // NOTE: sequential state always uses <=, so every register sees pre-edge values.
    always_ff @(posedge PCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            data_q  <= '0;
            href_q  <= 1'b0;
            href_d  <= 1'b0;
            vsync_q <= VSYNC_POL;
            vsync_d <= VSYNC_POL;
        end else begin
            data_q  <= DATA_IN;
            href_q  <= HREF;
            href_d  <= href_q;
            vsync_q <= VSYNC;
            vsync_d <= vsync_q;
        end
    end

    assign href_rise   = href_q & ~href_d;
    assign href_fall   = ~href_q & href_d;
    assign fs          = (vsync_q == VSYNC_POL) && (vsync_d != VSYNC_POL);
    assign frame_start = fs && ((state == WAIT_FRAME && ENABLE) || state == ACTIVE);

    // NOTE: every always_comb output gets a value on every path, so no latch can form.
    always_comb begin
        phase_cur = href_rise ? '0 : phase;
        x_cur     = href_rise ? '0 : x_cnt;
        capturing = (state == ACTIVE) && !fs && href_q && (line_ok || href_rise);
        pix_done  = capturing && (phase_cur == PH_W'(BPP - 1));
    end

    if (BPP == 1) begin : g_pack1
        assign pix_next = data_q;
    end else begin : g_packn
        logic [(BPP-1)*DATA_W-1:0] acc;
        always_ff @(posedge PCLK or negedge RESET_N) begin
            if (!RESET_N)       acc <= '0;
            else if (capturing) acc <= pix_next[(BPP-1)*DATA_W-1:0];
        end
        assign pix_next = {acc, data_q};
    end

`ifdef DVP_CAPTURE_CROP_EN
    logic [CNT_W-1:0] x0_r, y0_r, w_r, h_r;
    logic [CNT_W:0]   x_end, y_end;
    always_ff @(posedge PCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            x0_r <= '0;
            y0_r <= '0;
            w_r  <= '0;
            h_r  <= '0;
        end else if (frame_start) begin
            x0_r <= CROP_X0;
            y0_r <= CROP_Y0;
            w_r  <= CROP_W;
            h_r  <= CROP_H;
        end
    end
    assign x_end  = {1'b0, x0_r} + {1'b0, w_r};
    assign y_end  = {1'b0, y0_r} + {1'b0, h_r};
    assign in_win = (x_cur >= x0_r) && ({1'b0, x_cur} < x_end) &&
                    (y_cnt >= y0_r) && ({1'b0, y_cnt} < y_end);
`else
    assign in_win = 1'b1;
`endif

    always_ff @(posedge PCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            phase       <= '0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            line_ok     <= 1'b0;
            line_acc    <= '0;
            stage       <= '0;
            stage_valid <= 1'b0;
            sof_pending <= 1'b0;
            push        <= '0;
            push_valid  <= 1'b0;
            FRAME_CNT   <= '0;
            LINE_CNT    <= '0;
        end else begin
            push_valid <= 1'b0;
            case (state)
                IDLE:       if (ENABLE) state <= WAIT_FRAME;
                WAIT_FRAME: if (!ENABLE) state <= IDLE; else if (fs) state <= ACTIVE;
                ACTIVE:     if (fs && !ENABLE) state <= IDLE;
                default:    state <= IDLE;
            endcase

            if (frame_start) begin
                // A line still open at FS is aborted along with its staged pixel.
                stage_valid <= 1'b0;
                phase       <= '0;
                x_cnt       <= '0;
                y_cnt       <= '0;
                line_ok     <= 1'b0;
                line_acc    <= '0;
                sof_pending <= 1'b1;
                if (state == ACTIVE) begin
                    LINE_CNT  <= line_acc;
                    FRAME_CNT <= FRAME_CNT + 16'd1;
                end
            end else if (state == ACTIVE) begin
                if (href_rise) begin
                    line_ok  <= 1'b1;
                    line_acc <= sat_inc(line_acc);
                end
                if (capturing) phase <= pix_done ? '0 : phase_cur + 1'b1;
                if (pix_done) begin
                    x_cnt <= sat_inc(x_cur);
                    if (in_win) begin
                        if (stage_valid) begin
                            push       <= stage;
                            push_valid <= 1'b1;
                        end
                        stage       <= '{sof: sof_pending, eol: 1'b0, data: pix_next};
                        stage_valid <= 1'b1;
                        sof_pending <= 1'b0;
                    end
                end else if (href_rise) begin
                    x_cnt <= '0;
                end
                if (href_fall) begin
                    if (stage_valid) begin
                        push       <= '{sof: stage.sof, eol: 1'b1, data: stage.data};
                        push_valid <= 1'b1;
                    end
                    stage_valid <= 1'b0;
                    line_ok     <= 1'b0;
                    if (line_ok) y_cnt <= sat_inc(y_cnt);
                end
            end
        end
    end

    pix_t          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, pop, wr_ok, ovf_set, drop_frame;

    assign full      = (count == FULL_CNT);
    assign PIX_VALID = (count != '0);
    assign pop       = PIX_VALID && PIX_READY;
    assign wr_ok     = push_valid && !drop_frame && (!full || pop);
    assign ovf_set   = push_valid && !drop_frame && full && !pop;
    assign head      = mem[rd_ptr];
    assign PIX_DATA  = PIX_VALID ? head.data : '0;
    assign PIX_SOF   = PIX_VALID && head.sof;
    assign PIX_EOL   = PIX_VALID && head.eol;

    // NOTE: storage is not reset; outputs are gated by count, so stale entries never show.
    always_ff @(posedge PCLK) begin
        if (wr_ok) mem[wr_ptr] <= push;
    end

    always_ff @(posedge PCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_frame <= 1'b0;
            OVERFLOW   <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (frame_start)  drop_frame <= 1'b0;
            else if (ovf_set) drop_frame <= 1'b1;
            if (OVF_CLR)      OVERFLOW <= 1'b0;
            else if (ovf_set) OVERFLOW <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dvp_capture.sv
// Scoreboard bench for dvp_capture: directed frames, overflow, enable drop, reset, crop.
`timescale 1ns/1ps
module tb_dvp_capture;
    localparam int DATA_W = 8;
    localparam int BPP    = 2;
    localparam int CNT_W  = 11;

    logic              PCLK = 1'b0;
    logic              RESET_N = 1'b0;
    logic [DATA_W-1:0] DATA_IN = '0;
    logic              HREF = 1'b0, VSYNC = 1'b0, ENABLE = 1'b0;
    logic [15:0]       PIX_DATA;
    logic              PIX_SOF, PIX_EOL, PIX_VALID;
    logic              PIX_READY = 1'b1;
    logic              OVERFLOW;
    logic              OVF_CLR = 1'b0;
    logic [15:0]       FRAME_CNT;
    logic [CNT_W-1:0]  LINE_CNT;
`ifdef DVP_CAPTURE_CROP_EN
    logic [CNT_W-1:0]  CROP_X0 = '0, CROP_Y0 = '0, CROP_W = '1, CROP_H = '1;
`endif

    dvp_capture #(.DATA_W(DATA_W), .BPP(BPP), .FIFO_DEPTH(16), .CNT_W(CNT_W), .VSYNC_POL(1'b1)) dut (
        .PCLK(PCLK), .RESET_N(RESET_N), .DATA_IN(DATA_IN), .HREF(HREF), .VSYNC(VSYNC),
        .ENABLE(ENABLE), .PIX_DATA(PIX_DATA), .PIX_SOF(PIX_SOF), .PIX_EOL(PIX_EOL),
        .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY), .OVERFLOW(OVERFLOW), .OVF_CLR(OVF_CLR),
        .FRAME_CNT(FRAME_CNT), .LINE_CNT(LINE_CNT)
`ifdef DVP_CAPTURE_CROP_EN
        , .CROP_X0(CROP_X0), .CROP_Y0(CROP_Y0), .CROP_W(CROP_W), .CROP_H(CROP_H)
`endif
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic [15:0] data;
        logic        sof;
        logic        eol;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_out = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens on the next rising edge when valid && ready here.
    always @(negedge PCLK) begin
        exp_t e;
        if (RESET_N && PIX_VALID && PIX_READY) begin
            n_out++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pixel: got data=0x%h sof=%b eol=%b, expected none",
                         PIX_DATA, PIX_SOF, PIX_EOL);
            end else begin
                e = sb.pop_front();
                check("pixel{data,sof,eol}", {14'd0, PIX_DATA, PIX_SOF, PIX_EOL}, {14'd0, e});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic frame_start();
        HREF  = 1'b0;
        VSYNC = 1'b1;
        tick(4);
        VSYNC = 1'b0;
        tick(4);
    endtask

    task automatic send_line(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            HREF    = 1'b1;
            DATA_IN = first + 8'(i);
            tick(1);
        end
        HREF    = 1'b0;
        DATA_IN = '0;
        tick(4);
    endtask

    task automatic expect_px(input logic [15:0] d, input logic sof, input logic eol);
        sb.push_back('{data: d, sof: sof, eol: eol});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        check(name, sb.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, PIX_VALID, 0);
        check({tag, "_data"}, PIX_DATA, 0);
        check({tag, "_sof"}, PIX_SOF, 0);
        check({tag, "_eol"}, PIX_EOL, 0);
        check({tag, "_overflow"}, OVERFLOW, 0);
        check({tag, "_frame_cnt"}, FRAME_CNT, 0);
        check({tag, "_line_cnt"}, LINE_CNT, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check_reset_values("reset");
        RESET_N = 1'b1;
        tick(2);

        // Two lines of four 2-byte pixels.
        ENABLE = 1'b1;
        tick(2);
        frame_start();
        expect_px(16'h1011, 1, 0); expect_px(16'h1213, 0, 0);
        expect_px(16'h1415, 0, 0); expect_px(16'h1617, 0, 1);
        expect_px(16'h1011, 0, 0); expect_px(16'h1213, 0, 0);
        expect_px(16'h1415, 0, 0); expect_px(16'h1617, 0, 1);
        send_line(8'h10, 8);
        send_line(8'h10, 8);
        wait_drain("drain_basic", 50);
        frame_start();
        check("line_cnt_after_f1", LINE_CNT, 2);
        check("frame_cnt_after_f1", FRAME_CNT, 1);

        // Odd byte count: trailing partial pixel dropped.
        expect_px(16'h2021, 1, 0); expect_px(16'h2223, 0, 1);
        send_line(8'h20, 5);
        wait_drain("drain_odd", 50);
        frame_start();
        check("line_cnt_after_f2", LINE_CNT, 1);
        check("frame_cnt_after_f2", FRAME_CNT, 2);

        // Overflow: 20 pixels into a 16-deep FIFO with the sink stalled.
        PIX_READY = 1'b0;
        n_out = 0;
        for (int i = 0; i < 16; i++) expect_px({8'(2 * i), 8'(2 * i + 1)}, i == 0, 1'b0);
        send_line(8'h00, 40);
        tick(4);
        check("overflow_set", OVERFLOW, 1);
        check("full_valid", PIX_VALID, 1);
        check("stalled_out", n_out, 0);
        PIX_READY = 1'b1;
        wait_drain("drain_overflow", 60);
        tick(10);
        check("overflow_delivered", n_out, 16);
        frame_start();
        check("frame_cnt_after_ovf", FRAME_CNT, 3);
        check("line_cnt_after_ovf", LINE_CNT, 1);
        expect_px(16'h3031, 1, 0); expect_px(16'h3233, 0, 1);
        send_line(8'h30, 4);
        wait_drain("drain_after_ovf", 50);
        check("overflow_sticky", OVERFLOW, 1);
        OVF_CLR = 1'b1;
        tick(1);
        OVF_CLR = 1'b0;
        check("overflow_cleared", OVERFLOW, 0);

        // ENABLE dropped mid-frame: the frame completes, nothing after the next FS.
        frame_start();
        n_out = 0;
        expect_px(16'h4041, 1, 0); expect_px(16'h4243, 0, 1);
        send_line(8'h40, 4);
        ENABLE = 1'b0;
        expect_px(16'h4445, 0, 0); expect_px(16'h4647, 0, 1);
        send_line(8'h44, 4);
        frame_start();
        check("line_cnt_disable", LINE_CNT, 2);
        send_line(8'h50, 4);
        frame_start();
        send_line(8'h58, 4);
        wait_drain("drain_disable", 50);
        tick(10);
        check("disable_out_count", n_out, 4);

        // Reset asserted mid-line with pixels waiting in the FIFO.
        ENABLE = 1'b1;
        tick(2);
        frame_start();
        PIX_READY = 1'b0;
        send_line(8'h60, 4);
        check("pre_reset_valid", PIX_VALID, 1);
        check("pre_reset_sof", PIX_SOF, 1);
        check("pre_reset_frame_cnt", FRAME_CNT, 5);
        HREF    = 1'b1;
        DATA_IN = 8'h68;
        tick(3);
        RESET_N = 1'b0;
        #1;
        check_reset_values("midline_reset");
        HREF = 1'b0;
        tick(2);
        RESET_N   = 1'b1;
        PIX_READY = 1'b1;
        n_out     = 0;
        send_line(8'h70, 4);
        tick(6);
        check("no_output_before_fs", n_out, 0);
        frame_start();
        expect_px(16'h7071, 1, 0); expect_px(16'h7273, 0, 1);
        send_line(8'h70, 4);
        wait_drain("drain_after_reset", 50);

`ifdef DVP_CAPTURE_CROP_EN
        // Crop window x=1..2 on line 1 of a 4x3 frame.
        CROP_X0 = 11'd1; CROP_W = 11'd2; CROP_Y0 = 11'd1; CROP_H = 11'd1;
        frame_start();
        n_out = 0;
        expect_px(16'h9293, 1, 0); expect_px(16'h9495, 0, 1);
        send_line(8'h80, 8);
        send_line(8'h90, 8);
        send_line(8'hA0, 8);
        wait_drain("drain_crop", 50);
        tick(10);
        check("crop_out_count", n_out, 2);
        CROP_W = 11'd0;
        frame_start();
        send_line(8'hB0, 8);
        send_line(8'hC0, 8);
        tick(10);
        check("crop_zero_width", n_out, 2);
`endif

        tick(5);
        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
